mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 88 ++++++++
 rtl/mc_ctrl_dec.sv | 41 ++++
 rtl/mc_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, funct codes,
// FSM state codes, datapath select encodings and the one-hot instruction classes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [1:0] EOP_SIGN  = 2'b00;
    localparam logic [1:0] EOP_ZERO  = 2'b01;
    localparam logic [1:0] EOP_LUI   = 2'b10;
    localparam logic [1:0] EOP_BR    = 2'b11;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;

    localparam logic [1:0] NPC_PC4   = 2'b00;
    localparam logic [1:0] NPC_BR    = 2'b01;
    localparam logic [1:0] NPC_JUMP  = 2'b10;
    localparam logic [1:0] NPC_GPR   = 2'b11;

    localparam logic [1:0] RD_RD     = 2'b00;
    localparam logic [1:0] RD_RT     = 2'b01;
    localparam logic [1:0] RD_R31    = 2'b10;

    localparam logic [1:0] WD_ALU    = 2'b00;
    localparam logic [1:0] WD_MEM    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam int CLS_W  = 11;
    localparam int C_ADDU = 0;
    localparam int C_SUBU = 1;
    localparam int C_ORI  = 2;
    localparam int C_LUI  = 3;
    localparam int C_LW   = 4;
    localparam int C_SW   = 5;
    localparam int C_BEQ  = 6;
    localparam int C_J    = 7;
    localparam int C_JAL  = 8;
    localparam int C_JR   = 9;
    localparam int C_ILL  = 10;

    typedef logic [CLS_W-1:0] cls_t;

    typedef struct packed {
        logic [1:0] eop;
        logic [2:0] aluOp;
        logic       aluSrc;
    } exec_ctl_t;

    // Datapath setup chosen in S_EXEC and kept stable through S_MEM/S_WB.
    function automatic exec_ctl_t execCtl(input cls_t cls);
        exec_ctl_t c;
        c = '{eop: EOP_SIGN, aluOp: ALU_ADD, aluSrc: 1'b0};
        if (cls[C_BEQ]) begin
            c = '{eop: EOP_BR, aluOp: ALU_SUB, aluSrc: 1'b0};
        end else if (cls[C_SUBU]) begin
            c = '{eop: EOP_SIGN, aluOp: ALU_SUB, aluSrc: 1'b0};
        end else if (cls[C_ORI]) begin
            c = '{eop: EOP_ZERO, aluOp: ALU_OR, aluSrc: 1'b1};
        end else if (cls[C_LUI]) begin
            c = '{eop: EOP_LUI, aluOp: ALU_PASSB, aluSrc: 1'b1};
        end else if (cls[C_LW] || cls[C_SW]) begin
            c = '{eop: EOP_SIGN, aluOp: ALU_ADD, aluSrc: 1'b1};
        end
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Instruction classifier: maps op/funct to a one-hot class vector.
// MC_CTRL_JAL_EN enables the jal/jr classes; without it they decode as illegal.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output cls_t       o_cls
);

    always_comb begin
        o_cls = '0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_cls[C_ADDU] = 1'b1;
                    FN_SUBU: o_cls[C_SUBU] = 1'b1;
`ifdef MC_CTRL_JAL_EN
                    FN_JR:   o_cls[C_JR]   = 1'b1;
`else
                    FN_JR:   o_cls[C_ILL]  = 1'b1;
`endif
                    default: o_cls[C_ILL]  = 1'b1;
                endcase
            end
            OP_J:    o_cls[C_J]   = 1'b1;
`ifdef MC_CTRL_JAL_EN
            OP_JAL:  o_cls[C_JAL] = 1'b1;
`else
            OP_JAL:  o_cls[C_ILL] = 1'b1;
`endif
            OP_BEQ:  o_cls[C_BEQ] = 1'b1;
            OP_ORI:  o_cls[C_ORI] = 1'b1;
            OP_LUI:  o_cls[C_LUI] = 1'b1;
            OP_LW:   o_cls[C_LW]  = 1'b1;
            OP_SW:   o_cls[C_SW]  = 1'b1;
            default: o_cls[C_ILL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM (fetch/decode/exec/mem/wb) with a memory wait counter.
// Optional jal/jr support is selected by MC_CTRL_JAL_EN inside mc_ctrl_dec.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic [1:0] npc_op,
    output logic [1:0] eop,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [2:0] state,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cntNext;
    logic       w_memDone;
    cls_t       w_cls;
    exec_ctl_t  w_ctl;

    mc_ctrl_dec u_dec (
        .i_op    (op),
        .i_funct (funct),
        .o_cls   (w_cls)
    );

    assign w_ctl     = execCtl(w_cls);
    assign w_memDone = (r_cnt >= 4'(MEM_WAIT));
    assign state     = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cntNext;
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        w_cntNext = r_cnt;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_wr    = 1'b0;
        npc_op    = NPC_PC4;
        eop       = EOP_SIGN;
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        reg_dst   = RD_RD;
        wd_sel    = WD_ALU;
        illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_wr  = 1'b1;
                pc_wr  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                eop = EOP_BR;
                if (w_cls[C_J]) begin
                    pc_wr  = 1'b1;
                    npc_op = NPC_JUMP;
                end else if (w_cls[C_JAL]) begin
                    pc_wr   = 1'b1;
                    npc_op  = NPC_JUMP;
                    reg_wr  = 1'b1;
                    reg_dst = RD_R31;
                    wd_sel  = WD_PC;
                end else if (w_cls[C_JR]) begin
                    pc_wr  = 1'b1;
                    npc_op = NPC_GPR;
                end else if (w_cls[C_ILL]) begin
                    illegal = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                {eop, alu_op, alu_src} = w_ctl;
                if (w_cls[C_BEQ]) begin
                    npc_op = NPC_BR;
                    pc_wr  = zero;
                end else if (w_cls[C_LW] || w_cls[C_SW]) begin
                    w_next    = S_MEM;
                    w_cntNext = 4'd0;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                {eop, alu_op, alu_src} = w_ctl;
                w_cntNext = r_cnt + 4'd1;
                if (!w_memDone) begin
                    w_next = S_MEM;
                end else if (w_cls[C_SW]) begin
                    mem_wr = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                {eop, alu_op, alu_src} = w_ctl;
                reg_wr  = 1'b1;
                reg_dst = (w_cls[C_ADDU] || w_cls[C_SUBU]) ? RD_RD : RD_RT;
                wd_sel  = w_cls[C_LW] ? WD_MEM : WD_ALU;
            end
            default: w_next = S_FETCH;
        endcase
        // Writes are suppressed for the whole reset cycle so an abandoned instruction never commits.
        if (reset) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            reg_wr  = 1'b0;
            mem_wr  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule
